// File: rtl/branch_predictor_btb_pkg.sv
// Shared types and constants for the branch target buffer and its flush sweep.
package branch_predictor_btb_pkg;

  localparam logic [1:0] CNT_INIT = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_t;

  // Per-entry control fields; tag and target widths depend on the instance, so they sit beside this.
  typedef struct packed {
    logic       valid;
    logic       is_jump;
    logic [1:0] cnt;
  } btb_entry_t;

  function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Bundle of the fetch-side lookup and execute-side resolution signals of the BTB.
interface branch_predictor_btb_if #(
  parameter int IADDR_SPACE_BITS = 32
);
  logic                        flush;
  logic [IADDR_SPACE_BITS-1:0] fetch_pc;
  logic                        pred_taken;
  logic [IADDR_SPACE_BITS-1:0] pred_target;
  logic                        ex_valid;
  logic [IADDR_SPACE_BITS-1:0] ex_pc;
  logic                        cmp;
  logic                        branch_pred;
  logic                        inst_jal_jalr;
  logic                        inst_branch;
  logic [IADDR_SPACE_BITS-1:0] pc;
  logic [IADDR_SPACE_BITS-1:0] pc_next;
  logic [IADDR_SPACE_BITS-1:0] pc_target;
  logic                        pc_select;
  logic [IADDR_SPACE_BITS-1:0] redirect_target;
  logic                        busy;
  logic [15:0]                 mispred_cnt;

  modport master (
    output flush, fetch_pc, ex_valid, ex_pc, cmp, branch_pred, inst_jal_jalr, inst_branch,
           pc, pc_next, pc_target,
    input  pred_taken, pred_target, pc_select, redirect_target, busy, mispred_cnt
  );

  modport slave (
    input  flush, fetch_pc, ex_valid, ex_pc, cmp, branch_pred, inst_jal_jalr, inst_branch,
           pc, pc_next, pc_target,
    output pred_taken, pred_target, pc_select, redirect_target, busy, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_btb_pc_redirect.sv
// Execute-stage redirect decision: compares the actual branch outcome with what fetch did.
module pc_redirect #(
  parameter int IADDR_SPACE_BITS = 32
) (
  input  logic                        i_ex_valid,
  input  logic                        i_cmp,
  input  logic                        i_branch_pred,
  input  logic                        i_inst_jal_jalr,
  input  logic                        i_inst_branch,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc_next,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc_target,
  output logic                        o_actual_taken,
  output logic                        o_pc_select,
  output logic [IADDR_SPACE_BITS-1:0] o_pc_target
);

  logic pred_ok;
  logic fetched_taken;

  always_comb begin
    o_actual_taken = i_inst_jal_jalr | (i_inst_branch & i_cmp);
    pred_ok        = (i_pc_target == i_pc);
    // Fetch effectively went taken only if it predicted taken and landed on the right target.
    fetched_taken  = i_branch_pred & pred_ok;
    o_pc_select    = i_ex_valid & (o_actual_taken ^ fetched_taken);
    o_pc_target    = fetched_taken ? i_pc_next : i_pc_target;
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit counters, redirect logic and a flush sweep.
//   state    | meaning
//   ST_IDLE  | lookups and updates active
//   ST_FLUSH | clearing one valid bit per cycle, lookups/updates suppressed
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int IADDR_SPACE_BITS  = 32,
  parameter int BTB_ENTRIES       = 16,
  parameter int BRANCH_PREDICTION = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_flush,
  input  logic [IADDR_SPACE_BITS-1:0] i_fetch_pc,
  output logic                        o_pred_taken,
  output logic [IADDR_SPACE_BITS-1:0] o_pred_target,
  input  logic                        i_ex_valid,
  input  logic [IADDR_SPACE_BITS-1:0] i_ex_pc,
  input  logic                        i_cmp,
  input  logic                        i_branch_pred,
  input  logic                        i_inst_jal_jalr,
  input  logic                        i_inst_branch,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc_next,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc_target,
  output logic                        o_pc_select,
  output logic [IADDR_SPACE_BITS-1:0] o_pc_target,
  output logic                        o_busy,
  output logic [15:0]                 o_mispred_cnt
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = IADDR_SPACE_BITS - IDX - 2;

  btb_entry_t                  meta_q [BTB_ENTRIES];
  logic [TAG_W-1:0]            tag_q  [BTB_ENTRIES];
  logic [IADDR_SPACE_BITS-1:0] tgt_q  [BTB_ENTRIES];

  flush_state_t state_q, state_d;
  logic [IDX-1:0] flush_idx_q;

  logic [IDX-1:0]   fetch_idx, ex_idx;
  logic [TAG_W-1:0] fetch_tag, ex_tag;
  logic             fetch_hit, ex_hit, upd_en, actual_taken;
  logic             unused_addr_lsbs;

  assign fetch_idx = i_fetch_pc[IDX+1:2];
  assign fetch_tag = i_fetch_pc[IADDR_SPACE_BITS-1:IDX+2];
  assign ex_idx    = i_ex_pc[IDX+1:2];
  assign ex_tag    = i_ex_pc[IADDR_SPACE_BITS-1:IDX+2];
  assign unused_addr_lsbs = ^{i_fetch_pc[1:0], i_ex_pc[1:0]};

  pc_redirect #(.IADDR_SPACE_BITS(IADDR_SPACE_BITS)) u_pc_redirect (
    .i_ex_valid      (i_ex_valid),
    .i_cmp           (i_cmp),
    .i_branch_pred   (i_branch_pred),
    .i_inst_jal_jalr (i_inst_jal_jalr),
    .i_inst_branch   (i_inst_branch),
    .i_pc            (i_pc),
    .i_pc_next       (i_pc_next),
    .i_pc_target     (i_pc_target),
    .o_actual_taken  (actual_taken),
    .o_pc_select     (o_pc_select),
    .o_pc_target     (o_pc_target)
  );

  // Lookup reads pre-update table contents; an update at the same index lands next edge.
  always_comb begin
    fetch_hit     = meta_q[fetch_idx].valid && (tag_q[fetch_idx] == fetch_tag);
    o_pred_taken  = (BRANCH_PREDICTION != 0) && fetch_hit && !o_busy &&
                    (meta_q[fetch_idx].is_jump || meta_q[fetch_idx].cnt[1]);
    o_pred_target = o_pred_taken ? tgt_q[fetch_idx] : '0;
  end

  always_comb begin
    ex_hit = meta_q[ex_idx].valid && (tag_q[ex_idx] == ex_tag);
    upd_en = (BRANCH_PREDICTION != 0) && i_ex_valid &&
             (i_inst_branch || i_inst_jal_jalr) && !o_busy;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) meta_q[i] <= '0;
    end else if (o_busy) begin
      meta_q[flush_idx_q].valid <= 1'b0;
    end else if (upd_en) begin
      if (ex_hit)
        meta_q[ex_idx].cnt <= cnt_step(meta_q[ex_idx].cnt, actual_taken);
      else if (actual_taken)
        meta_q[ex_idx] <= '{valid: 1'b1, is_jump: i_inst_jal_jalr, cnt: CNT_INIT};
    end
  end

  // Tag/target are qualified by the valid bit, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (upd_en && actual_taken) begin
      tgt_q[ex_idx] <= i_pc_target;
      if (!ex_hit) tag_q[ex_idx] <= ex_tag;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      flush_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= (state_q == ST_FLUSH) ? flush_idx_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_flush) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_idx_q == IDX'(BTB_ENTRIES - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q == ST_FLUSH);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)       o_mispred_cnt <= '0;
    else if (o_pc_select) o_mispred_cnt <= o_mispred_cnt + 16'd1;
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: allocation, counters, aliasing, flush, reset, wrap.
module tb_branch_predictor_btb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_btb_if #(.IADDR_SPACE_BITS(32)) bif();

  branch_predictor_btb #(
    .IADDR_SPACE_BITS(32), .BTB_ENTRIES(16), .BRANCH_PREDICTION(1)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_flush         (bif.flush),
    .i_fetch_pc      (bif.fetch_pc),
    .o_pred_taken    (bif.pred_taken),
    .o_pred_target   (bif.pred_target),
    .i_ex_valid      (bif.ex_valid),
    .i_ex_pc         (bif.ex_pc),
    .i_cmp           (bif.cmp),
    .i_branch_pred   (bif.branch_pred),
    .i_inst_jal_jalr (bif.inst_jal_jalr),
    .i_inst_branch   (bif.inst_branch),
    .i_pc            (bif.pc),
    .i_pc_next       (bif.pc_next),
    .i_pc_target     (bif.pc_target),
    .o_pc_select     (bif.pc_select),
    .o_pc_target     (bif.redirect_target),
    .o_busy          (bif.busy),
    .o_mispred_cnt   (bif.mispred_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_mis = 0;
  int busy_cycles;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ex;
    bif.ex_valid = 1'b0; bif.inst_branch = 1'b0; bif.inst_jal_jalr = 1'b0;
    bif.cmp = 1'b0; bif.branch_pred = 1'b0;
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic bp, input logic [31:0] fetched,
                          input logic [31:0] pnext, input logic [31:0] tgt,
                          input logic cmp, input logic br, input logic jal);
    bif.ex_valid = 1'b1; bif.ex_pc = pc; bif.branch_pred = bp; bif.pc = fetched;
    bif.pc_next = pnext; bif.pc_target = tgt; bif.cmp = cmp;
    bif.inst_branch = br; bif.inst_jal_jalr = jal;
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input logic bp,
                         input logic [31:0] fetched, input logic [31:0] pnext,
                         input logic [31:0] tgt, input logic cmp, input logic br,
                         input logic jal, input logic exp_sel, input logic [31:0] exp_tgt);
    drive_ex(pc, bp, fetched, pnext, tgt, cmp, br, jal);
    #1;
    check_val({tag, "_sel"}, {31'd0, bif.pc_select}, {31'd0, exp_sel});
    if (exp_sel) begin
      check_val({tag, "_tgt"}, bif.redirect_target, exp_tgt);
      exp_mis++;
    end
    tick;
    clear_ex;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_taken,
                        input logic [31:0] exp_tgt);
    bif.fetch_pc = pc;
    #1;
    check_val({tag, "_taken"}, {31'd0, bif.pred_taken}, {31'd0, exp_taken});
    check_val({tag, "_target"}, bif.pred_target, exp_tgt);
  endtask

  task automatic check_mis(input string tag);
    check_val(tag, {16'd0, bif.mispred_cnt}, 32'(exp_mis & 32'hFFFF));
  endtask

  initial begin
    bif.flush = 1'b0; bif.fetch_pc = '0; bif.ex_pc = '0; bif.pc = '0;
    bif.pc_next = '0; bif.pc_target = '0;
    clear_ex;
    tick; tick;
    lookup("rst", 32'h100, 1'b0, 32'h0);
    check_val("rst_busy", {31'd0, bif.busy}, 32'd0);
    check_mis("rst_mis");
    rst_n = 1'b1;
    tick;
    lookup("cold", 32'h100, 1'b0, 32'h0);

    // First taken resolution allocates; same-cycle lookup still sees the old entry.
    bif.fetch_pc = 32'h100;
    drive_ex(32'h100, 1'b0, 32'h104, 32'h104, 32'h200, 1'b1, 1'b1, 1'b0);
    #1;
    check_val("no_bypass", {31'd0, bif.pred_taken}, 32'd0);
    check_val("alloc_sel", {31'd0, bif.pc_select}, 32'd1);
    check_val("alloc_tgt", bif.redirect_target, 32'h200);
    exp_mis++;
    tick;
    clear_ex;
    lookup("alloc", 32'h100, 1'b1, 32'h200);

    resolve("nt1", 32'h100, 1'b1, 32'h200, 32'h104, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 32'h104);
    resolve("nt2", 32'h100, 1'b1, 32'h200, 32'h104, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 32'h104);
    lookup("cnt0", 32'h100, 1'b0, 32'h0);
    resolve("nt3", 32'h100, 1'b0, 32'h104, 32'h104, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    resolve("tk1", 32'h100, 1'b0, 32'h104, 32'h104, 32'h200, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    lookup("cnt1", 32'h100, 1'b0, 32'h0);
    resolve("tk2", 32'h100, 1'b0, 32'h104, 32'h104, 32'h200, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    lookup("cnt2", 32'h100, 1'b1, 32'h200);
    resolve("tk_ok", 32'h100, 1'b1, 32'h200, 32'h104, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    resolve("bad_tgt", 32'h100, 1'b1, 32'h300, 32'h104, 32'h200, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    check_mis("mis_after_counters");

    // 0x140 shares index 0 with 0x100; a not-taken miss at 0x180 must not evict it.
    resolve("jal140", 32'h140, 1'b0, 32'h144, 32'h144, 32'h400, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400);
    lookup("own140", 32'h140, 1'b1, 32'h400);
    lookup("evict100", 32'h100, 1'b0, 32'h0);
    resolve("nt180", 32'h180, 1'b0, 32'h184, 32'h184, 32'h600, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    lookup("noalloc180", 32'h180, 1'b0, 32'h0);
    lookup("keep140", 32'h140, 1'b1, 32'h400);

    for (int i = 0; i < 16; i++)
      resolve("fill", 32'h1000 + 32'(4 * i), 1'b0, 32'h1004 + 32'(4 * i), 32'h1004 + 32'(4 * i),
              32'h2000 + 32'(4 * i), 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000 + 32'(4 * i));
    lookup("fill_lo", 32'h1000, 1'b1, 32'h2000);
    lookup("fill_hi", 32'h103C, 1'b1, 32'h203C);
    check_mis("mis_after_fill");

    bif.flush = 1'b1;
    tick;
    bif.flush = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      bif.flush = (k == 2);
      if (k == 4) begin
        bif.fetch_pc = 32'h1000;
        drive_ex(32'h1010, 1'b0, 32'h1014, 32'h1014, 32'h5000, 1'b0, 1'b0, 1'b1);
      end
      #1;
      if (bif.busy) busy_cycles++;
      if (k == 4) begin
        check_val("flush_pred", {31'd0, bif.pred_taken}, 32'd0);
        check_val("flush_sel", {31'd0, bif.pc_select}, 32'd1);
        check_val("flush_tgt", bif.redirect_target, 32'h5000);
        exp_mis++;
      end
      tick;
      clear_ex;
    end
    bif.flush = 1'b0;
    check_val("busy_cycles", 32'(busy_cycles), 32'd16);
    check_val("busy_done", {31'd0, bif.busy}, 32'd0);
    lookup("flushed_lo", 32'h1000, 1'b0, 32'h0);
    lookup("flushed_hi", 32'h103C, 1'b0, 32'h0);
    lookup("flushed_upd", 32'h1010, 1'b0, 32'h0);
    lookup("flushed_140", 32'h140, 1'b0, 32'h0);
    check_mis("mis_after_flush");

    // Reset in the middle of a sweep.
    resolve("pre_rst", 32'h1028, 1'b0, 32'h102C, 32'h102C, 32'h7000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7000);
    lookup("pre_rst_hit", 32'h1028, 1'b1, 32'h7000);
    bif.flush = 1'b1;
    tick;
    bif.flush = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    exp_mis = 0;
    #1;
    check_val("midrst_busy", {31'd0, bif.busy}, 32'd0);
    check_mis("midrst_mis");
    tick;
    rst_n = 1'b1;
    tick;
    check_val("postrst_busy", {31'd0, bif.busy}, 32'd0);
    lookup("postrst_miss", 32'h1028, 1'b0, 32'h0);

    // Non-branch op whose fetch went "taken" to the right address: redirects every cycle.
    drive_ex(32'h40, 1'b1, 32'h40, 32'h44, 32'h40, 1'b0, 1'b0, 1'b0);
    repeat (65535) tick;
    check_val("wrap_max", {16'd0, bif.mispred_cnt}, 32'h0000FFFF);
    tick;
    check_val("wrap_zero", {16'd0, bif.mispred_cnt}, 32'h0);
    clear_ex;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
